// File: rtl/imc_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imc_instr_fetch_ctrl
// Function : Loads a program into an instruction RAM, then streams it to the
//            decoder through a 2-entry output FIFO with ready/valid handshake.
// Revision : 1.0
// ============================================================================
module imc_instr_fetch_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RAM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  start,
    output logic                  mem_wr_cs,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_cs,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic                  instr_last,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]                r_load_cnt;
    logic [CW-1:0]                r_prog_len;
    logic [CW-1:0]                r_pc;
    logic                         r_load_err;
    logic [1:0][DATA_WIDTH-1:0]   r_fifo_data;
    logic [1:0]                   r_fifo_last;
    logic                         r_wr_ptr;
    logic                         r_rd_ptr;
    logic [1:0]                   r_fifo_cnt;
    logic                         r_inflight;
    logic                         r_inflight_last;

    logic          w_load_ready;
    logic          w_beat;
    logic [CW-1:0] w_wr_idx;
    logic          w_beat_last;
    logic          w_overflow;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_occupancy;
    logic          w_issue;
    logic          w_issue_last;
    logic          w_fetch_entry;

    assign w_load_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_beat       = load_valid && w_load_ready;
    // The first beat of a program is accepted straight from IDLE at address 0.
    assign w_wr_idx     = (r_state == S_IDLE) ? '0 : r_load_cnt;
    assign w_beat_last  = w_beat && load_last;
    assign w_overflow   = w_beat && !load_last && (w_wr_idx == CW'(RAM_DEPTH - 1));

    assign w_pop        = (r_fifo_cnt != 2'd0) && instr_ready;
    assign w_push       = r_inflight;
    // A pop in this cycle frees a slot, so the read stream can stay back-to-back.
    assign w_occupancy  = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_FETCH) && (w_occupancy < 3'd2);
    assign w_issue_last = w_issue && (r_pc == r_prog_len - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_state_nxt = (load_last || w_overflow) ? S_IDLE : S_LOAD;
                end else if (start) begin
                    w_state_nxt = (r_prog_len != '0) ? S_FETCH : S_DONE;
                end
            end
            S_LOAD: begin
                if (w_beat_last || w_overflow) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_fifo_cnt == 2'd0) && !r_inflight) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start && (r_prog_len != '0)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fetch_entry = (w_state_nxt == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_load_cnt      <= '0;
            r_prog_len      <= '0;
            r_pc            <= '0;
            r_load_err      <= 1'b0;
            r_fifo_data     <= '0;
            r_fifo_last     <= '0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_fifo_cnt      <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_beat) begin
                r_load_cnt <= w_wr_idx + 1'b1;
                if (r_state == S_IDLE) begin
                    r_load_err <= 1'b0;
                end
                if (w_beat_last) begin
                    r_prog_len <= w_wr_idx + 1'b1;
                end
                if (w_overflow) begin
                    r_prog_len <= CW'(RAM_DEPTH);
                    r_load_err <= 1'b1;
                end
            end

            if (w_fetch_entry) begin
                r_pc <= '0;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= mem_rd_data;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign load_ready  = w_load_ready;
    assign mem_wr_cs   = w_beat;
    assign mem_wr_en   = w_beat;
    assign mem_wr_addr = w_beat ? w_wr_idx[ADDR_WIDTH-1:0] : '0;
    assign mem_wr_data = w_beat ? load_data : '0;
    assign mem_rd_cs   = w_issue;
    assign mem_rd_en   = w_issue;
    assign mem_rd_addr = w_issue ? r_pc[ADDR_WIDTH-1:0] : '0;
    assign instr_valid = (r_fifo_cnt != 2'd0);
    assign instr_data  = instr_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign instr_last  = instr_valid && r_fifo_last[r_rd_ptr];
    assign prog_len    = r_prog_len;
    assign busy        = (r_state == S_LOAD) || (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign load_err    = r_load_err;

endmodule
`default_nettype wire
